// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile_if
// Purpose  : Execute-result, decode-read and write-back-latch signal bundle
//            for wb_regfile.
// Revision : 1.0 - initial release
// ============================================================================
interface wb_regfile_if #(
    parameter int DATA_W = 32
);
    localparam int c_ADDR_W = 5;

    logic                stall_i;
    logic [c_ADDR_W-1:0] wd_i;
    logic                wreg_i;
    logic [DATA_W-1:0]   wdata_i;
    logic                re1_i;
    logic [c_ADDR_W-1:0] raddr1_i;
    logic [DATA_W-1:0]   rdata1_o;
    logic                re2_i;
    logic [c_ADDR_W-1:0] raddr2_i;
    logic [DATA_W-1:0]   rdata2_o;
    logic [c_ADDR_W-1:0] wb_wd_o;
    logic                wb_wreg_o;
    logic [DATA_W-1:0]   wb_wdata_o;

    modport master (
        output stall_i, wd_i, wreg_i, wdata_i,
        output re1_i, raddr1_i, re2_i, raddr2_i,
        input  rdata1_o, rdata2_o,
        input  wb_wd_o, wb_wreg_o, wb_wdata_o
    );

    modport slave (
        input  stall_i, wd_i, wreg_i, wdata_i,
        input  re1_i, raddr1_i, re2_i, raddr2_i,
        output rdata1_o, rdata2_o,
        output wb_wd_o, wb_wreg_o, wb_wdata_o
    );
endinterface
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : wb_regfile
// Purpose  : Write-back latch plus 2-read/1-write register file with
//            forwarding. Define REGFILE_EX_FWD_EN to forward execute results.
// Revision : 1.0 - initial release
// ============================================================================
module wb_regfile #(
    parameter int NUM_REGS = 32,
    parameter int DATA_W   = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    wb_regfile_if.slave      bus
);
    localparam int c_ADDR_W = 5;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [c_ADDR_W-1:0] wb_wd_q,    wb_wd_d;
    logic                wb_wreg_q,  wb_wreg_d;
    logic [DATA_W-1:0]   wb_wdata_q, wb_wdata_d;

    // A stall drops the execute result and inserts a bubble.
    always_comb begin
        wb_wd_d    = bus.wd_i;
        wb_wreg_d  = bus.wreg_i;
        wb_wdata_d = bus.wdata_i;
        if (bus.stall_i) begin
            wb_wd_d    = '0;
            wb_wreg_d  = 1'b0;
            wb_wdata_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_wd_q    <= '0;
            wb_wreg_q  <= 1'b0;
            wb_wdata_q <= '0;
        end else begin
            wb_wd_q    <= wb_wd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
        end
    end

    // Commit retires the latch entry regardless of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_wreg_q && (wb_wd_q != '0)) begin
            regs_q[wb_wd_q] <= wb_wdata_q;
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd
        logic                w_re;
        logic [c_ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0]   w_rdata;

        assign w_re    = (p == 0) ? bus.re1_i    : bus.re2_i;
        assign w_raddr = (p == 0) ? bus.raddr1_i : bus.raddr2_i;

        // Youngest in-flight result wins over older ones and committed state.
        always_comb begin
            w_rdata = regs_q[w_raddr];
            if (!w_re || (w_raddr == '0)) begin
                w_rdata = '0;
`ifdef REGFILE_EX_FWD_EN
            end else if (bus.wreg_i && (bus.wd_i == w_raddr)) begin
                w_rdata = bus.wdata_i;
`endif
            end else if (wb_wreg_q && (wb_wd_q == w_raddr)) begin
                w_rdata = wb_wdata_q;
            end
        end
    end

    assign bus.rdata1_o   = g_rd[0].w_rdata;
    assign bus.rdata2_o   = g_rd[1].w_rdata;
    assign bus.wb_wd_o    = wb_wd_q;
    assign bus.wb_wreg_o  = wb_wreg_q;
    assign bus.wb_wdata_o = wb_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_regfile
// Purpose  : Randomized scoreboard bench for wb_regfile against a
//            behavioural model of committed and in-flight results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;
    logic clk = 1'b0;
    logic rst;

    wb_regfile_if #(.DATA_W(32)) bus ();

    wb_regfile #(.NUM_REGS(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] r1;
        logic [31:0] r2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
    } exp_t;

    exp_t expq [$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: architectural state plus the single result awaiting retirement.
    logic [31:0] mem [32];
    logic [4:0]  pend_wd;
    logic        pend_wreg;
    logic [31:0] pend_wdata;

    // Values currently presented to the DUT.
    logic        c_rst, c_stall, c_wreg, c_re1, c_re2;
    logic [4:0]  c_wd, c_a1, c_a2;
    logic [31:0] c_wdata;

    function automatic logic [31:0] exp_read(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
`ifdef REGFILE_EX_FWD_EN
        if (c_wreg && c_wd == a) return c_wdata;
`endif
        if (pend_wreg && pend_wd == a) return pend_wdata;
        return mem[a];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, exp);
        end
    endtask

    task automatic drive();
        rst          = c_rst;
        bus.stall_i  = c_stall;
        bus.wd_i     = c_wd;
        bus.wreg_i   = c_wreg;
        bus.wdata_i  = c_wdata;
        bus.re1_i    = c_re1;
        bus.raddr1_i = c_a1;
        bus.re2_i    = c_re2;
        bus.raddr2_i = c_a2;
    endtask

    // One clock: advance the model across the edge, then present new inputs.
    task automatic cycle(input logic rs, input logic st, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdat,
                         input logic r1, input logic [4:0] a1,
                         input logic r2, input logic [4:0] a2);
        exp_t e;
        @(posedge clk);
        if (c_rst) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'd0;
            pend_wd = 5'd0; pend_wreg = 1'b0; pend_wdata = 32'd0;
        end else begin
            if (pend_wreg && pend_wd != 5'd0) mem[pend_wd] = pend_wdata;
            if (c_stall) begin
                pend_wd = 5'd0; pend_wreg = 1'b0; pend_wdata = 32'd0;
            end else begin
                pend_wd = c_wd; pend_wreg = c_wreg; pend_wdata = c_wdata;
            end
        end
        #1;
        c_rst = rs; c_stall = st; c_wd = wd; c_wreg = wr; c_wdata = wdat;
        c_re1 = r1; c_a1 = a1; c_re2 = r2; c_a2 = a2;
        drive();
        e.r1    = exp_read(r1, a1);
        e.r2    = exp_read(r2, a2);
        e.wd    = pend_wd;
        e.wreg  = pend_wreg;
        e.wdata = pend_wdata;
        expq.push_back(e);
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom);
        return 5'($urandom_range(0, 7));
    endfunction

    // Monitor: compares once per cycle, mid-period.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                check("rdata1",   bus.rdata1_o,           e.r1);
                check("rdata2",   bus.rdata2_o,           e.r2);
                check("wb_wd",    32'(bus.wb_wd_o),       32'(e.wd));
                check("wb_wreg",  32'(bus.wb_wreg_o),     32'(e.wreg));
                check("wb_wdata", bus.wb_wdata_o,         e.wdata);
            end
        end
    end

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        pend_wd = 5'd0; pend_wreg = 1'b0; pend_wdata = 32'd0;
        c_rst = 1'b1; c_stall = 1'b0; c_wd = 5'd0; c_wreg = 1'b0; c_wdata = 32'd0;
        c_re1 = 1'b0; c_a1 = 5'd0; c_re2 = 1'b0; c_a2 = 5'd0;
        drive();

        cycle(1, 0, 0, 0, 0, 1, 1, 1, 2);
        cycle(0, 0, 0, 0, 0, 1, 1, 1, 2);

        // Preload 1..31, then reset and sweep reads.
        for (int i = 1; i < 32; i++)
            cycle(0, 0, 5'(i), 1, 32'hA500_0000 | 32'(i), 1, 5'(i - 1), 1, 5'(i));
        cycle(0, 0, 0, 0, 0, 1, 31, 1, 30);
        cycle(1, 0, 0, 0, 0, 1, 5, 1, 17);
        for (int i = 0; i < 32; i++)
            cycle(0, 0, 0, 0, 0, 1, 5'(i), 1, 5'(31 - i));

        // Basic write of reg 5.
        cycle(0, 0, 5, 1, 32'hDEADBEEF, 1, 5, 1, 5);
        cycle(0, 0, 0, 0, 0, 1, 5, 0, 5);
        cycle(0, 0, 0, 0, 0, 1, 5, 1, 5);
        cycle(0, 0, 0, 0, 0, 1, 5, 1, 0);

        // Register 0 is never written and always reads zero.
        cycle(0, 0, 0, 1, 32'h12345678, 1, 0, 1, 0);
        cycle(0, 0, 0, 1, 32'h12345678, 1, 0, 1, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 1, 0);

        // Forwarding priority on reg 3: committed 1, latched 2, executing 3.
        cycle(0, 0, 3, 1, 32'h1, 1, 3, 1, 3);
        cycle(0, 0, 3, 1, 32'h2, 1, 3, 1, 3);
        cycle(0, 0, 3, 1, 32'h3, 1, 3, 1, 3);
        cycle(0, 0, 3, 1, 32'h3, 1, 3, 0, 3);
        cycle(0, 0, 0, 0, 0, 1, 3, 1, 3);

        // Stall: reg 7 retires, reg 8 result is dropped.
        cycle(0, 0, 7, 1, 32'hAA, 1, 7, 1, 8);
        cycle(0, 1, 8, 1, 32'hBB, 1, 7, 1, 8);
        cycle(0, 0, 8, 0, 32'hBB, 1, 7, 1, 8);
        cycle(0, 0, 0, 0, 0, 1, 7, 1, 8);

        // Reset while reg 9 is in the latch loses it.
        cycle(0, 0, 9, 1, 32'h55, 1, 9, 1, 9);
        cycle(1, 0, 0, 0, 0, 1, 9, 1, 9);
        cycle(0, 0, 0, 0, 0, 1, 9, 1, 9);
        cycle(0, 0, 0, 0, 0, 1, 9, 1, 9);

        // Random traffic.
        for (int n = 0; n < 2000; n++) begin
            logic [4:0] a1;
            a1 = rand_addr();
            cycle(($urandom_range(0, 59) == 0),
                  ($urandom_range(0, 5) == 0),
                  rand_addr(),
                  ($urandom_range(0, 3) != 0),
                  $urandom(),
                  ($urandom_range(0, 7) != 0), a1,
                  ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 4) == 0) ? a1 : rand_addr());
        end

        for (int k = 0; k < 10 && expq.size() != 0; k++) @(negedge clk);
        #1;
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
